elevator_scan_controller: RTL

Sequential N-floor elevator car controller: latches hall and cabin calls, runs a SCAN policy (keep going in the current direction while calls remain ahead, then reverse), steps the car in half-floor increments, and times the door. It supersedes the fixed 3-floor, per-state combinational next-state logic. Here the floor count and door dwell are parameters, and the pending-call memory and the door timer are held inside the block. It sits between the button debouncers and the car/door actuator drivers.

---
 rtl/elevator_scan_controller_pkg.sv | 36 +++
 rtl/elevator_scan_controller_if.sv | 26 ++
 rtl/elevator_scan_controller_req_bank.sv | 43 ++++
 rtl/elevator_scan_controller.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/elevator_scan_controller_pkg.sv
// Shared definitions for the elevator SCAN controller.
//   DIR_* : direction encodings driven on dir
//   state_t : car FSM states
//   scan_span() : reduces a pending-request vector to above/below flags
package elevator_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Upper bound on the floor count accepted by scan_span().
  localparam int unsigned MAX_FLOORS = 64;

  typedef enum logic [1:0] {
    ST_FLOOR,
    ST_OPEN,
    ST_HALF
  } state_t;

  typedef struct packed {
    logic above;
    logic below;
  } span_t;

  function automatic span_t scan_span(input logic [MAX_FLOORS-1:0] req,
                                      input logic [31:0] pos);
    span_t s;
    s = '0;
    for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
      if (req[i] && (i > pos)) s.above = 1'b1;
      if (req[i] && (i < pos)) s.below = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Button/actuator bundle for the elevator SCAN controller.
//   master : button source (debouncers), observes car outputs
//   slave  : the controller, drives pos/half/open/dir/pending
interface elevator_scan_controller_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FW         = $clog2(NUM_FLOORS)
);
  logic [NUM_FLOORS-1:0] button_up;
  logic [NUM_FLOORS-1:0] button_down;
  logic [NUM_FLOORS-1:0] button_in;
  logic [FW-1:0]         pos;
  logic                  half;
  logic                  open;
  logic [1:0]            dir;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output button_up, button_down, button_in,
    input  pos, half, open, dir, pending
  );

  modport slave (
    input  button_up, button_down, button_in,
    output pos, half, open, dir, pending
  );
endinterface

// File: rtl/elevator_scan_controller_req_bank.sv
// Latched hall/cabin call memory.
//   button_*  : single-cycle call pulses
//   supp_*    : per-floor suppress (press absorbed by an open door)
//   clr_*     : per-floor clear on door opening
//   req_*     : latched request vectors
// Top hall-up and bottom hall-down calls are ignored.
module elevator_req_bank #(
  parameter int NUM_FLOORS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] button_up,
  input  logic [NUM_FLOORS-1:0] button_down,
  input  logic [NUM_FLOORS-1:0] button_in,
  input  logic [NUM_FLOORS-1:0] supp_up,
  input  logic [NUM_FLOORS-1:0] supp_down,
  input  logic [NUM_FLOORS-1:0] supp_in,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_down,
  input  logic [NUM_FLOORS-1:0] clr_in,
  output logic [NUM_FLOORS-1:0] req_up,
  output logic [NUM_FLOORS-1:0] req_down,
  output logic [NUM_FLOORS-1:0] req_in
);
  logic [NUM_FLOORS-1:0] up_mask;
  logic [NUM_FLOORS-1:0] down_mask;

  assign up_mask   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  assign down_mask = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  // Clear wins over a same-edge press: the opening door serves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_up   <= '0;
      req_down <= '0;
      req_in   <= '0;
    end else begin
      req_up   <= (req_up   | (button_up   & up_mask   & ~supp_up))   & ~clr_up;
      req_down <= (req_down | (button_down & down_mask & ~supp_down)) & ~clr_down;
      req_in   <= (req_in   | (button_in   & ~supp_in))               & ~clr_in;
    end
  end
endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor elevator car controller with SCAN scheduling and door timer.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : buttons in; pos/half/open/dir/pending out
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int DOOR_CYCLES = 3,
  parameter int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  elevator_scan_controller_if.slave bus
);
  localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DOOR_CYCLES - 1);

  state_t                state, nxt_state;
  logic [FW-1:0]         pos;
  logic                  half, open;
  logic [1:0]            dir, nxt_dir;
  logic [TW-1:0]         timer;
  logic [NUM_FLOORS-1:0] req_up, req_down, req_in, pend;
  logic [NUM_FLOORS-1:0] supp_up, supp_down, supp_in;
  logic [NUM_FLOORS-1:0] clr_up, clr_down, clr_in;
  logic [NUM_FLOORS-1:0] hall_up, hall_down;
  logic                  here_up, here_dn, reload;
  span_t                 span;

  elevator_req_bank #(.NUM_FLOORS(NUM_FLOORS)) u_req_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_up  (bus.button_up),
    .button_down(bus.button_down),
    .button_in  (bus.button_in),
    .supp_up    (supp_up),
    .supp_down  (supp_down),
    .supp_in    (supp_in),
    .clr_up     (clr_up),
    .clr_down   (clr_down),
    .clr_in     (clr_in),
    .req_up     (req_up),
    .req_down   (req_down),
    .req_in     (req_in)
  );

  assign pend      = req_up | req_down | req_in;
  assign span      = scan_span(MAX_FLOORS'(pend), 32'(pos));
  assign here_up   = req_in[pos] | req_up[pos];
  assign here_dn   = req_in[pos] | req_down[pos];
  assign hall_up   = bus.button_up   & {1'b0, {(NUM_FLOORS-1){1'b1}}};
  assign hall_down = bus.button_down & {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  always_comb begin
    nxt_state = state;
    nxt_dir   = dir;
    supp_up   = '0;
    supp_down = '0;
    supp_in   = '0;
    clr_up    = '0;
    clr_down  = '0;
    clr_in    = '0;
    reload    = 1'b0;
    unique case (state)
      ST_FLOOR: begin
        case (dir)
          DIR_UP: begin
            if (here_up)             nxt_state = ST_OPEN;
            else if (span.above)     nxt_state = ST_HALF;
            else if (req_down[pos]) begin
              nxt_state = ST_OPEN;
              nxt_dir   = DIR_DOWN;
            end else if (span.below) begin
              nxt_state = ST_HALF;
              nxt_dir   = DIR_DOWN;
            end else                 nxt_dir   = DIR_STOP;
          end
          DIR_DOWN: begin
            if (here_dn)             nxt_state = ST_OPEN;
            else if (span.below)     nxt_state = ST_HALF;
            else if (req_up[pos]) begin
              nxt_state = ST_OPEN;
              nxt_dir   = DIR_UP;
            end else if (span.above) begin
              nxt_state = ST_HALF;
              nxt_dir   = DIR_UP;
            end else                 nxt_dir   = DIR_STOP;
          end
          default: begin
            if (pend[pos])           nxt_state = ST_OPEN;
            else if (span.above) begin
              nxt_state = ST_HALF;
              nxt_dir   = DIR_UP;
            end else if (span.below) begin
              nxt_state = ST_HALF;
              nxt_dir   = DIR_DOWN;
            end
          end
        endcase
      end
      ST_OPEN: begin
        // Presses the open door already serves are absorbed and extend dwell.
        supp_in[pos] = 1'b1;
        if (dir != DIR_DOWN) supp_up[pos]   = 1'b1;
        if (dir != DIR_UP)   supp_down[pos] = 1'b1;
        reload = |((bus.button_in & supp_in) | (hall_up & supp_up) |
                   (hall_down & supp_down));
        if (!reload && (timer == '0)) nxt_state = ST_FLOOR;
      end
      default: nxt_state = ST_FLOOR;
    endcase
    if ((state == ST_FLOOR) && (nxt_state == ST_OPEN)) begin
      clr_in[pos] = 1'b1;
      if (nxt_dir != DIR_DOWN) clr_up[pos]   = 1'b1;
      if (nxt_dir != DIR_UP)   clr_down[pos] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FLOOR;
      pos   <= '0;
      half  <= 1'b0;
      open  <= 1'b0;
      dir   <= DIR_STOP;
      timer <= '0;
    end else begin
      state <= nxt_state;
      dir   <= nxt_dir;
      if ((state == ST_FLOOR) && (nxt_state == ST_OPEN)) begin
        open  <= 1'b1;
        timer <= RELOAD;
      end
      if ((state == ST_FLOOR) && (nxt_state == ST_HALF)) half <= 1'b1;
      if (state == ST_OPEN) begin
        if (reload)              timer <= RELOAD;
        else if (timer == '0)    open  <= 1'b0;
        else                     timer <= timer - 1'b1;
      end
      if (state == ST_HALF) begin
        half <= 1'b0;
        pos  <= (dir == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
      end
    end
  end

  assign bus.pos     = pos;
  assign bus.half    = half;
  assign bus.open    = open;
  assign bus.dir     = dir;
  assign bus.pending = pend;
endmodule
